seven_segment_scan_display: RTL and testbench
=============================================

# seven_segment_scan_display

Parametrised multiplexed seven-segment display controller: generalises the fixed 8-digit hex wrapper to N_DIGITS digits with a built-in scan timer, frame-synchronous tear-free update, per-digit decimal points, leading-zero blanking and PWM brightness. Sits between any status/debug register source and the board's anode/cathode pins, replacing the wrapper-plus-driver pair.

## Interface
- N_DIGITS, 8: number of digits scanned, 1..16.
- DIV_BITS, 14: slot length is 2^DIV_BITS clocks.
- PWM_BITS, 3: brightness resolution; must satisfy PWM_BITS <= DIV_BITS.

- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  display enable; 0 forces all anodes off, timers keep running.
- load  input  1  one-cycle strobe: capture bin/dp into the staging register.
- bin  input  4*N_DIGITS  hex nibbles, digit 0 = bits [3:0].
- dp  input  N_DIGITS  decimal point per digit, 1 = lit.
- lzb  input  1  leading-zero blanking enable.
- brightness  input  PWM_BITS  duty level, 0 = dimmest, all-ones = brightest.
- AN  output  N_DIGITS  anodes, active-low.
- CA..CG  output  1 each  segments a..g, active-low.
- DP  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse at end of each frame.

## Operation
- Scan timer: slot_cnt (DIV_BITS) increments every clock, wraps to 0; on wrap idx increments, wrapping N_DIGITS-1 -> 0.
- Frame end: cycle with idx = N_DIGITS-1 and slot_cnt all-ones.
- Staging: load=1 -> staged <= {bin, dp}, pending <= 1.
- Commit: at frame end with pending=1 (value held before this edge) -> shadow <= staged, pending <= 0. Displayed data comes only from shadow; a frame is never torn.
- load coincident with frame end: commit uses the old staged value; new value captured, pending stays 1, committed at next frame end.
- Decode: idx selects shadow nibble; package function maps 0-F to active-low a..g (0: g off; 1: b,c only; 8: all on; F: a,e,f,g).
- Leading-zero blanking: with lzb=1, digit k>0 is blanked (segments all 1) when nibbles k..N_DIGITS-1 are all zero. Digit 0 never blanked. DP still follows dp[k].
- PWM: phase p = slot_cnt[DIV_BITS-1 -: PWM_BITS]; anode idx asserted iff en=1, slot_cnt != 0 (ghosting guard), and p <= brightness.
- Reset (any time, asynchronous): slot_cnt, idx, staged, shadow, pending = 0; AN all ones; CA..CG, DP = 1; frame_done = 0. Operation resumes at idx 0, slot_cnt 0 on first clock after release.

## Timing
- All outputs registered; AN/segments/DP/frame_done reflect counter state of the previous cycle (latency 1).
- Slot = 2^DIV_BITS cycles; frame = N_DIGITS * 2^DIV_BITS cycles.
- frame_done high for exactly one cycle per frame, the cycle after frame end.
- load -> visible on outputs: at first slot-0 output after next frame end (max one frame + 1 cycle).
- Duty per slot = ((brightness+1) * 2^(DIV_BITS-PWM_BITS) - 1) / 2^DIV_BITS.
- en change takes effect on outputs after 1 cycle.

## Structure
- Package seven_segment_pkg: seg_decode function (4-bit -> 7-bit active-low), segment bit-position constants, SEG_OFF = 7'h7F.
- Sub-module seven_segment_scan_timer: slot_cnt, idx, frame-end and PWM phase generation; top holds staging/shadow, blanking, decode and output registers.

## Test plan
- N=4, DIV_BITS=4, PWM_BITS=2, brightness=3, load bin=16'h1234 -> after next frame end, AN cycles 1110/1101/1011/0111 showing 4,3,2,1; each anode low 15 of 16 cycles (slot_cnt 0 off).
- brightness=0 -> each anode low only for slot_cnt 1..3 (3 cycles per slot); brightness=1 -> slot_cnt 1..7.
- lzb=1, bin=16'h0050 -> digits 3,2 blank (CA..CG all 1), digit 1 shows 5, digit 0 shows 0; bin=0 -> only digit 0 shows 0.
- load mid-frame with 16'hABCD, then 16'hFFFF on frame-end cycle -> next frame shows ABCD entirely, following frame FFFF; frame_done one pulse per 64 cycles.
- dp=4'b0100, en toggled 0 -> DP low only in slot 2; en=0 -> AN=1111 next cycle while frame_done continues.
- reset asserted mid-slot -> AN=1111, segments/DP=1 immediately (asynchronous); after release, shadow=0 and digit 0 shows 0.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment scan display: segment bit
// positions, the blank pattern and the hex-to-segment decoder.
package seven_segment_pkg;

  // Bit positions of segments a..g inside a 7-bit segment vector.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments dark (active-low).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Hex nibble to active-low segment pattern, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_scan_timer.sv
// Scan timer: slot counter, digit index, frame-end flag and PWM phase.
module seven_segment_scan_timer #(
  parameter int N_DIGITS = 8,
  parameter int DIV_BITS = 14,
  parameter int PWM_BITS = 3,
  parameter int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic [DIV_BITS-1:0] slot_cnt,
  output logic [IDX_W-1:0]    idx,
  output logic                frame_end,
  output logic [PWM_BITS-1:0] phase
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  // Free-running slot counter; the digit index advances when a slot wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge value of slot_cnt, so the wrap test below sees the old count.
      slot_cnt <= slot_cnt + DIV_BITS'(1);
      if (&slot_cnt) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
    end
  end

  assign frame_end = (&slot_cnt) && (idx == LAST_IDX);
  assign phase     = slot_cnt[DIV_BITS-1 -: PWM_BITS];

endmodule

// File: rtl/seven_segment_scan_display.sv
// Multiplexed seven-segment controller: staged/shadow data for tear-free
// frames, leading-zero blanking, per-digit decimal points, PWM brightness.
module seven_segment_scan_display
  import seven_segment_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DIV_BITS = 14,
  parameter int PWM_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] bin,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  lzb,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [N_DIGITS-1:0]   AN,
  output logic                  CA,
  output logic                  CB,
  output logic                  CC,
  output logic                  CD,
  output logic                  CE,
  output logic                  CF,
  output logic                  CG,
  output logic                  DP,
  output logic                  frame_done
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [DIV_BITS-1:0]   slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  frame_end;
  logic [PWM_BITS-1:0]   phase;

  logic [4*N_DIGITS-1:0] staged_bin;
  logic [N_DIGITS-1:0]   staged_dp;
  logic [4*N_DIGITS-1:0] shadow_bin;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic                  pending;

  logic [N_DIGITS-1:0]   zero_from;
  logic [3:0]            nibble;
  logic                  blank;
  logic [N_DIGITS-1:0]   an_next;
  logic [6:0]            seg_q;

  seven_segment_scan_timer #(
    .N_DIGITS (N_DIGITS),
    .DIV_BITS (DIV_BITS),
    .PWM_BITS (PWM_BITS),
    .IDX_W    (IDX_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .slot_cnt  (slot_cnt),
    .idx       (idx),
    .frame_end (frame_end),
    .phase     (phase)
  );

  // Capture loads into staging; move staging to shadow only at frame end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data registers are cleared too, so digit 0 shows 0 after
      // reset instead of whatever the flops powered up with.
      staged_bin <= '0;
      staged_dp  <= '0;
      shadow_bin <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        staged_bin <= bin;
        staged_dp  <= dp;
      end
      if (frame_end && pending) begin
        shadow_bin <= staged_bin;
        shadow_dp  <= staged_dp;
      end
      // A load on the frame-end cycle keeps pending set for the next frame.
      pending <= load || (pending && !frame_end);
    end
  end

  // zero_from[k] is set when nibbles k..N_DIGITS-1 of the shadow are all zero.
  always_comb begin
    // NOTE: every bit gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    zero_from = '0;
    zero_from[N_DIGITS-1] = (shadow_bin[4*(N_DIGITS-1) +: 4] == 4'h0);
    for (int k = N_DIGITS - 2; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (shadow_bin[4*k +: 4] == 4'h0);
    end
  end

  // Select the current digit, decide blanking and the gated anode pattern.
  always_comb begin
    nibble  = shadow_bin[idx*4 +: 4];
    blank   = lzb && (idx != '0) && zero_from[idx];
    an_next = '1;
    if (en && (slot_cnt != '0) && (phase <= brightness)) begin
      an_next[idx] = 1'b0;
    end
  end

  // Register all pin-facing outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      AN         <= '1;
      seg_q      <= SEG_OFF;
      DP         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      AN         <= an_next;
      seg_q      <= blank ? SEG_OFF : seg_decode(nibble);
      DP         <= ~shadow_dp[idx];
      frame_done <= frame_end;
    end
  end

  assign CA = seg_q[SEG_A];
  assign CB = seg_q[SEG_B];
  assign CC = seg_q[SEG_C];
  assign CD = seg_q[SEG_D];
  assign CE = seg_q[SEG_E];
  assign CF = seg_q[SEG_F];
  assign CG = seg_q[SEG_G];

endmodule

// File: tb/tb_seven_segment_scan_display.sv
// Directed bench for seven_segment_scan_display with N=4, DIV_BITS=4,
// PWM_BITS=2: slot = 16 cycles, frame = 64 cycles.
module tb_seven_segment_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        load;
  logic [15:0] bin;
  logic [3:0]  dp;
  logic        lzb;
  logic [1:0]  brightness;
  logic [3:0]  AN;
  logic        CA, CB, CC, CD, CE, CF, CG;
  logic        DP;
  logic        frame_done;
  logic [6:0]  segs;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Active-low patterns, bit 0 = a.
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, SA = 7'h08, SB = 7'h03;
  localparam logic [6:0] SC = 7'h46, SD = 7'h21, SF = 7'h0E, SX = 7'h7F;

  seven_segment_scan_display #(
    .N_DIGITS (4),
    .DIV_BITS (4),
    .PWM_BITS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .bin        (bin),
    .dp         (dp),
    .lzb        (lzb),
    .brightness (brightness),
    .AN         (AN),
    .CA         (CA),
    .CB         (CB),
    .CC         (CC),
    .CD         (CD),
    .CE         (CE),
    .CF         (CF),
    .CG         (CG),
    .DP         (DP),
    .frame_done (frame_done)
  );

  assign segs = {CG, CF, CE, CD, CC, CB, CA};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until the edge that ends a frame has just occurred.
  task automatic align();
    for (int i = 0; i < 64; i++) begin
      if (cyc % 64 == 0) break;
      step();
    end
  endtask

  // Check a whole frame; must start with cyc % 64 == 0.
  task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dp_exp, input int bright,
                           input logic en_exp);
    logic [6:0] segx [4];
    logic [3:0] exp_an;
    logic       exp_dp;
    logic       exp_fd;
    int         t, slot, d;
    segx[0] = s0; segx[1] = s1; segx[2] = s2; segx[3] = s3;
    for (int i = 0; i < 64; i++) begin
      step();
      t    = cyc - 1;
      slot = t % 16;
      d    = (t / 16) % 4;
      exp_an = 4'hF;
      if (en_exp && slot != 0 && (slot / 4) <= bright) exp_an[d] = 1'b0;
      exp_dp = ~dp_exp[d];
      exp_fd = (cyc % 64 == 0);
      check($sformatf("an@%0d", cyc), AN, exp_an);
      check($sformatf("seg@%0d", cyc), segs, segx[d]);
      check($sformatf("dp@%0d", cyc), DP, exp_dp);
      check($sformatf("frame_done@%0d", cyc), frame_done, exp_fd);
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; load = 1'b0; bin = '0; dp = '0;
    lzb = 1'b0; brightness = 2'd3;
    #12;
    check("rst_an", AN, 4'hF);
    check("rst_seg", segs, SX);
    check("rst_dp", DP, 1'b1);
    check("rst_fd", frame_done, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    cyc = 0;

    // State 0: digit 0, slot 0 -> guard keeps anode off, shadow 0 shows '0'.
    step();
    check("first_an", AN, 4'hF);
    check("first_seg", segs, S0);
    step();
    check("second_an", AN, 4'hE);

    // Load 1234 mid-frame; visible from the next frame only.
    step(); step(); step();
    bin = 16'h1234; load = 1'b1;
    step();
    load = 1'b0;
    align();
    check("fd_first_frame", frame_done, 1'b1);
    run_frame(S4, S3, S2, S1, 4'b0000, 3, 1'b1);

    // Brightness sweep.
    brightness = 2'd0;
    run_frame(S4, S3, S2, S1, 4'b0000, 0, 1'b1);
    brightness = 2'd1;
    run_frame(S4, S3, S2, S1, 4'b0000, 1, 1'b1);
    brightness = 2'd3;

    // Leading-zero blanking.
    lzb = 1'b1; bin = 16'h0050; load = 1'b1;
    step();
    load = 1'b0;
    align();
    run_frame(S0, S5, SX, SX, 4'b0000, 3, 1'b1);
    bin = 16'h0000; load = 1'b1;
    step();
    load = 1'b0;
    align();
    run_frame(S0, SX, SX, SX, 4'b0000, 3, 1'b1);
    lzb = 1'b0;

    // ABCD mid-frame, FFFF on the frame-end cycle.
    for (int i = 0; i < 10; i++) step();
    bin = 16'hABCD; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (cyc % 64 == 63) break;
      step();
    end
    bin = 16'hFFFF; load = 1'b1;
    step();
    load = 1'b0;
    run_frame(SD, SC, SB, SA, 4'b0000, 3, 1'b1);
    run_frame(SF, SF, SF, SF, 4'b0000, 3, 1'b1);

    // Decimal point on digit 2, then display disabled.
    bin = 16'h1234; dp = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    align();
    run_frame(S4, S3, S2, S1, 4'b0100, 3, 1'b1);
    en = 1'b0;
    run_frame(S4, S3, S2, S1, 4'b0100, 3, 1'b0);
    en = 1'b1;

    // Asynchronous reset in the middle of a lit slot.
    for (int i = 0; i < 6; i++) step();
    check("pre_rst_an", AN, 4'hE);
    reset = 1'b0;
    #1;
    check("async_an", AN, 4'hF);
    check("async_seg", segs, SX);
    check("async_dp", DP, 1'b1);
    check("async_fd", frame_done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    step();
    check("post_rst_an0", AN, 4'hF);
    check("post_rst_seg0", segs, S0);
    step();
    check("post_rst_an1", AN, 4'hE);
    check("post_rst_seg1", segs, S0);
    check("post_rst_dp1", DP, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
